// File: rtl/maze_walker_if.sv
// Handshake and map-ROM bundle for maze_walker.
// MAZE_STEP_COUNT_EN adds the steps counter output.
interface maze_walker_if;
    logic       move_req;
    logic [1:0] dir;
    logic       restart;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [8:0] rom_data;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic       busy;
    logic       move_done;
    logic       bump;
    logic       win;
`ifdef MAZE_STEP_COUNT_EN
    logic [7:0] steps;
`endif

    modport slave (
        input  move_req, dir, restart, rom_data,
        output rom_en, rom_addr, pos_x, pos_y, busy, move_done, bump, win
`ifdef MAZE_STEP_COUNT_EN
        , output steps
`endif
    );

    modport master (
        output move_req, dir, restart, rom_data,
        input  rom_en, rom_addr, pos_x, pos_y, busy, move_done, bump, win
`ifdef MAZE_STEP_COUNT_EN
        , input steps
`endif
    );
endinterface

// File: rtl/maze_walker.sv
// Player-position controller: fetches the target map row and moves only into open cells.
// Optional MAZE_STEP_COUNT_EN adds a saturating accepted-move counter (steps).
module maze_walker #(
    parameter logic [2:0] START_X = 3'd2,
    parameter logic [2:0] START_Y = 3'd0,
    parameter logic [2:0] GOAL_X  = 3'd0,
    parameter logic [2:0] GOAL_Y  = 3'd7
) (
    input  logic          clk,
    input  logic          rst_n,
    maze_walker_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, WIN} state_t;

    localparam bit START_IS_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    state_t     state_q, state_d;
    logic [2:0] pos_x_q, pos_x_d;
    logic [2:0] pos_y_q, pos_y_d;
    logic [2:0] tx_q, tx_d;
    logic [2:0] ty_q, ty_d;
    logic       move_done_q, move_done_d;
    logic       bump_q, bump_d;
    logic       win_q, win_d;

    logic       off_grid;
    logic [2:0] tgt_x;
    logic [2:0] tgt_y;
    logic [2:0] col_sel;
    logic       cell_open;

    always_comb begin
        off_grid = 1'b0;
        tgt_x    = pos_x_q;
        tgt_y    = pos_y_q;
        unique case (bus.dir)
            2'b00: if (pos_y_q == 3'd0) off_grid = 1'b1; else tgt_y = pos_y_q - 3'd1;
            2'b01: if (pos_y_q == 3'd7) off_grid = 1'b1; else tgt_y = pos_y_q + 3'd1;
            2'b10: if (pos_x_q == 3'd0) off_grid = 1'b1; else tgt_x = pos_x_q - 3'd1;
            2'b11: if (pos_x_q == 3'd7) off_grid = 1'b1; else tgt_x = pos_x_q + 3'd1;
            default: off_grid = 1'b1;
        endcase
    end

    // Column x lives at bit 7-x; the zero-extended index never reaches bit 8.
    assign col_sel   = 3'd7 - tx_q;
    assign cell_open = bus.rom_data[{1'b0, col_sel}];

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        move_done_d = 1'b0;
        bump_d      = 1'b0;
        win_d       = win_q;
        if (bus.restart) begin
            state_d = START_IS_GOAL ? WIN : IDLE;
            pos_x_d = START_X;
            pos_y_d = START_Y;
            win_d   = START_IS_GOAL;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pos_x_q == GOAL_X && pos_y_q == GOAL_Y) begin
                        state_d = WIN;
                        win_d   = 1'b1;
                    end else if (bus.move_req) begin
                        if (off_grid) begin
                            bump_d = 1'b1;
                        end else begin
                            tx_d    = tgt_x;
                            ty_d    = tgt_y;
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: state_d = CHECK;
                CHECK: begin
                    if (cell_open) begin
                        pos_x_d     = tx_q;
                        pos_y_d     = ty_q;
                        move_done_d = 1'b1;
                        if (tx_q == GOAL_X && ty_q == GOAL_Y) begin
                            state_d = WIN;
                            win_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bump_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                WIN: state_d = WIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_x_q     <= START_X;
            pos_y_q     <= START_Y;
            tx_q        <= '0;
            ty_q        <= '0;
            move_done_q <= 1'b0;
            bump_q      <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            move_done_q <= move_done_d;
            bump_q      <= bump_d;
            win_q       <= win_d;
        end
    end

    // ty_q only changes on an accepted request, so it doubles as the held ROM address.
    assign bus.rom_en    = (state_q == FETCH);
    assign bus.rom_addr  = ty_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.busy      = (state_q == FETCH) || (state_q == CHECK);
    assign bus.move_done = move_done_q;
    assign bus.bump      = bump_q;
    assign bus.win       = win_q;

`ifdef MAZE_STEP_COUNT_EN
    logic [7:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (bus.restart)
            steps_d = '0;
        else if (move_done_d && steps_q != '1)
            steps_d = steps_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) steps_q <= '0;
        else        steps_q <= steps_d;
    end

    assign bus.steps = steps_q;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker against a grid-level reference model.
// Build with +define+MAZE_STEP_COUNT_EN to also check the steps counter.
module tb_maze_walker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    maze_walker_if bus ();

    maze_walker #(
        .START_X(3'd2),
        .START_Y(3'd0),
        .GOAL_X (3'd0),
        .GOAL_Y (3'd7)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] maze [0:7];

    // Registered ROM; bit 8 is random to show it is ignored.
    always @(posedge clk)
        if (bus.rom_en) bus.rom_data <= {1'($urandom_range(0, 1)), maze[bus.rom_addr]};

    int pass_cnt  = 0;
    int total_cnt = 0;

    int mx, my, steps_m;
    bit won_m;

    int         lat, en_cnt;
    bit         got_done, got_bump, both;
    logic [2:0] addr_seen;

    function automatic int predict(input int x, input int y, input logic [1:0] d,
                                   output int nx, output int ny);
        logic [7:0] row;
        nx = x; ny = y;
        case (d)
            2'b00: ny = y - 1;
            2'b01: ny = y + 1;
            2'b10: nx = x - 1;
            default: nx = x + 1;
        endcase
        if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return 0;
        row = maze[ny];
        return row[7 - nx] ? 2 : 1;
    endfunction

    task automatic model_move(input logic [1:0] d, output int e_lat,
                              output bit e_done, output bit e_bump);
        int k, nx, ny;
        e_lat = 0; e_done = 0; e_bump = 0;
        if (won_m) return;
        k = predict(mx, my, d, nx, ny);
        if (k == 0) begin
            e_lat = 1; e_bump = 1;
        end else if (k == 1) begin
            e_lat = 3; e_bump = 1;
        end else begin
            e_lat = 3; e_done = 1;
            mx = nx; my = ny;
            if (steps_m < 255) steps_m++;
            if (mx == 0 && my == 7) won_m = 1;
        end
    endtask

    task automatic model_restart();
        mx = 2; my = 0; won_m = 0; steps_m = 0;
    endtask

    // Issue one request (called #1 after a posedge) and watch 8 cycles.
    task automatic observe(input logic [1:0] d);
        lat = 0; got_done = 0; got_bump = 0; both = 0; en_cnt = 0; addr_seen = '0;
        bus.move_req = 1'b1;
        bus.dir      = d;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.move_req = 1'b0;
            if (bus.rom_en) begin en_cnt++; addr_seen = bus.rom_addr; end
            if (bus.move_done && bus.bump) both = 1;
            if (lat == 0 && (bus.move_done || bus.bump)) begin
                lat = i; got_done = bus.move_done; got_bump = bus.bump;
            end
        end
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
        model_restart();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.pos_x, bus.pos_y} !== {3'd2, 3'd0}) $display("FAIL reset_pos: got %0d,%0d expected 2,0", bus.pos_x, bus.pos_y);
        else pass_cnt++;
        total_cnt++;
        if ({bus.win, bus.busy, bus.rom_en, bus.move_done, bus.bump} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {bus.win, bus.busy, bus.rom_en, bus.move_done, bus.bump});
        else pass_cnt++;
        total_cnt++;
        if (bus.rom_addr !== 3'd0) $display("FAIL reset_rom_addr: got %0d expected 0", bus.rom_addr);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_restart();
        // Asynchronous reset in the middle of a fetch.
        bus.move_req = 1'b1; bus.dir = 2'b11;
        @(posedge clk); #1;
        bus.move_req = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.busy, bus.rom_en, bus.pos_x, bus.pos_y} !== {1'b0, 1'b0, 3'd2, 3'd0})
            $display("FAIL async_abort: got busy=%b en=%b pos=%0d,%0d expected 0 0 2,0", bus.busy, bus.rom_en, bus.pos_x, bus.pos_y);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_move_accept();
        int el; bit ed, eb;
        model_move(2'b11, el, ed, eb);
        observe(2'b11);
        total_cnt++;
        if (lat !== 3 || got_done !== 1'b1) $display("FAIL accept_latency: got lat=%0d done=%b expected lat=3 done=1", lat, got_done);
        else pass_cnt++;
        total_cnt++;
        if (en_cnt !== 1 || addr_seen !== 3'd0) $display("FAIL accept_fetch: got en_cycles=%0d addr=%0d expected 1 0", en_cnt, addr_seen);
        else pass_cnt++;
        total_cnt++;
        if ({bus.pos_x, bus.pos_y} !== {3'(mx), 3'(my)}) $display("FAIL accept_pos: got %0d,%0d expected %0d,%0d", bus.pos_x, bus.pos_y, mx, my);
        else pass_cnt++;
        do_restart();
    endtask

    task automatic test_wall_bump();
        int el; bit ed, eb;
        model_move(2'b10, el, ed, eb);
        observe(2'b10);
        total_cnt++;
        if (lat !== el || got_bump !== eb || got_done !== ed)
            $display("FAIL wall_bump: got lat=%0d bump=%b done=%b expected lat=%0d bump=%b done=%b", lat, got_bump, got_done, el, eb, ed);
        else pass_cnt++;
        total_cnt++;
        if ({bus.pos_x, bus.pos_y} !== {3'd2, 3'd0}) $display("FAIL wall_pos: got %0d,%0d expected 2,0", bus.pos_x, bus.pos_y);
        else pass_cnt++;
    endtask

    task automatic test_off_grid();
        int el; bit ed, eb;
        model_move(2'b00, el, ed, eb);
        observe(2'b00);
        total_cnt++;
        if (lat !== el || got_bump !== eb) $display("FAIL offgrid_bump: got lat=%0d bump=%b expected lat=%0d bump=%b", lat, got_bump, el, eb);
        else pass_cnt++;
        total_cnt++;
        if (en_cnt !== 0) $display("FAIL offgrid_no_rom: got en_cycles=%0d expected 0", en_cnt);
        else pass_cnt++;
    endtask

    task automatic test_busy_and_restart();
        int el; bit ed, eb;
        model_move(2'b11, el, ed, eb);
        bus.move_req = 1'b1; bus.dir = 2'b11;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.busy, bus.rom_en} !== 2'b11) $display("FAIL busy_fetch: got busy=%b en=%b expected 1 1", bus.busy, bus.rom_en);
        else pass_cnt++;
        bus.dir = 2'b01;
        @(posedge clk); #1;
        bus.move_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.move_done !== 1'b1 || {bus.pos_x, bus.pos_y} !== {3'(mx), 3'(my)})
            $display("FAIL busy_drop: got done=%b pos=%0d,%0d expected 1 %0d,%0d", bus.move_done, bus.pos_x, bus.pos_y, mx, my);
        else pass_cnt++;
        repeat (3) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({bus.busy, bus.move_done, bus.bump} !== 3'b000 || {bus.pos_x, bus.pos_y} !== {3'(mx), 3'(my)})
                $display("FAIL busy_no_queue: got busy=%b done=%b bump=%b pos=%0d,%0d expected 000 %0d,%0d",
                         bus.busy, bus.move_done, bus.bump, bus.pos_x, bus.pos_y, mx, my);
            else pass_cnt++;
        end
        do_restart();
        // Restart lands while the down move is in CHECK; it must vanish.
        bus.move_req = 1'b1; bus.dir = 2'b01;
        @(posedge clk); #1;
        bus.move_req = 1'b0;
        @(posedge clk); #1;
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
        model_restart();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({bus.move_done, bus.bump, bus.busy} !== 3'b000 || {bus.pos_x, bus.pos_y} !== {3'd2, 3'd0})
                $display("FAIL restart_check: got done=%b bump=%b busy=%b pos=%0d,%0d expected 000 2,0",
                         bus.move_done, bus.bump, bus.busy, bus.pos_x, bus.pos_y);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_walk_to_goal();
        logic [1:0] path [0:8];
        int el; bit ed, eb;
        path[0] = 2'b01; path[1] = 2'b10;
        for (int i = 2; i < 8; i++) path[i] = 2'b01;
        path[8] = 2'b10;
        for (int i = 0; i < 9; i++) begin
            model_move(path[i], el, ed, eb);
            observe(path[i]);
            total_cnt++;
            if (lat !== el || got_done !== ed || got_bump !== eb || {bus.pos_x, bus.pos_y} !== {3'(mx), 3'(my)})
                $display("FAIL walk_step%0d: got lat=%0d done=%b pos=%0d,%0d expected lat=%0d done=%b pos=%0d,%0d",
                         i, lat, got_done, bus.pos_x, bus.pos_y, el, ed, mx, my);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.win !== 1'b1 || !won_m) $display("FAIL goal_win: got %b expected 1", bus.win);
        else pass_cnt++;
        observe(2'b11);
        total_cnt++;
        if (lat !== 0 || en_cnt !== 0 || bus.win !== 1'b1) $display("FAIL win_ignore: got lat=%0d en=%0d win=%b expected 0 0 1", lat, en_cnt, bus.win);
        else pass_cnt++;
`ifdef MAZE_STEP_COUNT_EN
        total_cnt++;
        if (bus.steps !== 8'(steps_m)) $display("FAIL steps_count: got %0d expected %0d", bus.steps, steps_m);
        else pass_cnt++;
`endif
        do_restart();
        total_cnt++;
        if (bus.win !== 1'b0 || {bus.pos_x, bus.pos_y} !== {3'd2, 3'd0})
            $display("FAIL restart_win: got win=%b pos=%0d,%0d expected 0 2,0", bus.win, bus.pos_x, bus.pos_y);
        else pass_cnt++;
`ifdef MAZE_STEP_COUNT_EN
        total_cnt++;
        if (bus.steps !== 8'd0) $display("FAIL steps_clear: got %0d expected 0", bus.steps);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random_walk();
        int el; bit ed, eb;
        logic [1:0] d;
        for (int n = 0; n < 60; n++) begin
            if (won_m || $urandom_range(0, 19) == 0) do_restart();
            d = 2'($urandom_range(0, 3));
            model_move(d, el, ed, eb);
            observe(d);
            total_cnt++;
            if (lat !== el || got_done !== ed || got_bump !== eb || both !== 1'b0)
                $display("FAIL rand%0d_pulse: got lat=%0d done=%b bump=%b both=%b expected lat=%0d done=%b bump=%b both=0",
                         n, lat, got_done, got_bump, both, el, ed, eb);
            else pass_cnt++;
            total_cnt++;
            if ({bus.pos_x, bus.pos_y} !== {3'(mx), 3'(my)} || bus.win !== won_m)
                $display("FAIL rand%0d_pos: got %0d,%0d win=%b expected %0d,%0d win=%b", n, bus.pos_x, bus.pos_y, bus.win, mx, my, won_m);
            else pass_cnt++;
`ifdef MAZE_STEP_COUNT_EN
            total_cnt++;
            if (bus.steps !== 8'(steps_m)) $display("FAIL rand%0d_steps: got %0d expected %0d", n, bus.steps, steps_m);
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        bus.move_req = 1'b0;
        bus.dir      = 2'b00;
        bus.restart  = 1'b0;
        maze[0] = 8'b0011_1111;
        maze[1] = 8'b0110_0001;
        for (int i = 2; i < 8; i++) begin
            r = 8'($urandom());
            maze[i] = r | 8'b0100_0000;
        end
        maze[7] = maze[7] | 8'b1000_0000;
        model_restart();
        test_reset();
        test_move_accept();
        test_wall_bump();
        test_off_grid();
        test_busy_and_restart();
        test_walk_to_goal();
        test_random_walk();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
